// File: rtl/axi_burst_req_arbiter_if.sv
// Bundles the requester-facing and engine-facing signals of the burst arbiter.
// The arbiter connects through the slave modport; requesters and the engine use master.
interface axi_burst_req_arbiter_if;
  logic        REQ0_VALID;
  logic        REQ0_READY;
  logic        REQ0_WRITE;
  logic [31:0] REQ0_ADDR;
  logic [7:0]  REQ0_LEN;
  logic        REQ0_DONE;
  logic [1:0]  REQ0_RESP;

  logic        REQ1_VALID;
  logic        REQ1_READY;
  logic        REQ1_WRITE;
  logic [31:0] REQ1_ADDR;
  logic [7:0]  REQ1_LEN;
  logic        REQ1_DONE;
  logic [1:0]  REQ1_RESP;

  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [7:0]  CMD_LEN;
  logic [3:0]  CMD_ID;

  logic        DONE_VALID;
  logic [1:0]  DONE_RESP;
  logic [3:0]  DONE_ID;
  logic        STRAY_DONE;

  modport slave (
    input  REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_LEN,
    output REQ0_READY, REQ0_DONE, REQ0_RESP,
    input  REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_LEN,
    output REQ1_READY, REQ1_DONE, REQ1_RESP,
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, CMD_ID,
    input  CMD_READY,
    input  DONE_VALID, DONE_RESP, DONE_ID,
    output STRAY_DONE
  );

  modport master (
    output REQ0_VALID, REQ0_WRITE, REQ0_ADDR, REQ0_LEN,
    input  REQ0_READY, REQ0_DONE, REQ0_RESP,
    output REQ1_VALID, REQ1_WRITE, REQ1_ADDR, REQ1_LEN,
    input  REQ1_READY, REQ1_DONE, REQ1_RESP,
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, CMD_ID,
    output CMD_READY,
    output DONE_VALID, DONE_RESP, DONE_ID,
    input  STRAY_DONE
  );
endinterface

// File: rtl/axi_burst_req_arbiter.sv
// Round-robin scheduler that feeds one burst command at a time from two requesters
// to a single AXI4 burst engine, screening out bursts that cross a 4 KB page.
module axi_burst_req_arbiter #(
  parameter int unsigned BEAT_BYTES = 4,
  parameter int unsigned MAX_LEN    = 16
) (
  input logic                    ACLK,
  input logic                    ARESETn,
  axi_burst_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_write_q, cmd_write_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_len_q, cmd_len_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  req_done_q, req_done_d;
  logic [1:0]  req0_resp_q, req0_resp_d;
  logic [1:0]  req1_resp_q, req1_resp_d;
  logic        stray_q, stray_d;

  logic        sel;
  logic        accept;
  logic        req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [13:0] beats;
  logic [13:0] end_off;
  logic        burst_err;
  logic        done_match;

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    sel = ~last_grant_q;
    if (bus.REQ0_VALID && !bus.REQ1_VALID) begin
      sel = 1'b0;
    end else if (bus.REQ1_VALID && !bus.REQ0_VALID) begin
      sel = 1'b1;
    end
  end

  assign accept         = (state_q == IDLE) && (bus.REQ0_VALID || bus.REQ1_VALID);
  assign bus.REQ0_READY = accept && !sel;
  assign bus.REQ1_READY = accept && sel;

  assign req_write = sel ? bus.REQ1_WRITE : bus.REQ0_WRITE;
  assign req_addr  = sel ? bus.REQ1_ADDR  : bus.REQ0_ADDR;
  assign req_len   = sel ? bus.REQ1_LEN   : bus.REQ0_LEN;

  // 14 bits hold the page offset plus the largest burst span without wrapping.
  assign beats     = 14'(req_len) + 14'd1;
  assign end_off   = 14'(req_addr[11:0]) + beats * 14'(BEAT_BYTES);
  assign burst_err = (beats > 14'(MAX_LEN)) || (end_off > 14'd4096);

  assign done_match = bus.DONE_VALID && (bus.DONE_ID == {3'b000, owner_q});

  always_comb begin
    // NOTE: every *_d starts from a default so no path through the case leaves a latch.
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_done_d   = 2'b00;
    req0_resp_d  = 2'b00;
    req1_resp_d  = 2'b00;
    stray_d      = stray_q | (bus.DONE_VALID && !((state_q == BUSY) && done_match));

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d     = sel;
          cmd_write_d = req_write;
          cmd_addr_d  = req_addr;
          cmd_len_d   = req_len;
          if (burst_err) begin
            state_d         = RESP;
            req_done_d[sel] = 1'b1;
            if (sel) req1_resp_d = 2'b10;
            else     req0_resp_d = 2'b10;
          end else begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.CMD_READY) begin
          cmd_valid_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (done_match) begin
          state_d             = RESP;
          req_done_d[owner_q] = 1'b1;
          if (owner_q) req1_resp_d = bus.DONE_RESP;
          else         req0_resp_d = bus.DONE_RESP;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!ARESETn) begin
      state_q      <= IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      req_done_q   <= 2'b00;
      req0_resp_q  <= 2'b00;
      req1_resp_q  <= 2'b00;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_done_q   <= req_done_d;
      req0_resp_q  <= req0_resp_d;
      req1_resp_q  <= req1_resp_d;
      stray_q      <= stray_d;
    end
  end

  assign bus.CMD_VALID  = cmd_valid_q;
  assign bus.CMD_WRITE  = cmd_write_q;
  assign bus.CMD_ADDR   = cmd_addr_q;
  assign bus.CMD_LEN    = cmd_len_q;
  assign bus.CMD_ID     = {3'b000, owner_q};
  assign bus.REQ0_DONE  = req_done_q[0];
  assign bus.REQ1_DONE  = req_done_q[1];
  assign bus.REQ0_RESP  = req0_resp_q;
  assign bus.REQ1_RESP  = req1_resp_q;
  assign bus.STRAY_DONE = stray_q;

endmodule

// File: tb/tb_axi_burst_req_arbiter.sv
// Directed and randomized bench for axi_burst_req_arbiter against a transaction-level
// model of one open burst (accepted -> sent to engine -> reported back).
module tb_axi_burst_req_arbiter;
  localparam int BEAT_BYTES = 4;
  localparam int MAX_LEN    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_burst_req_arbiter_if bus ();

  axi_burst_req_arbiter #(.BEAT_BYTES(BEAT_BYTES), .MAX_LEN(MAX_LEN)) dut (
    .ACLK   (clk),
    .ARESETn(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: at most one open burst; it is either waiting for the engine to take it,
  // waiting for its completion, or being reported back to its owner.
  bit          m_open, m_sent, m_rep, m_stray;
  int          m_owner, m_last;
  logic [1:0]  m_resp;
  logic        c_wr;
  logic [31:0] c_addr;
  logic [7:0]  c_len;

  function automatic int model_sel();
    if (bus.REQ0_VALID && bus.REQ1_VALID) return 1 - m_last;
    if (bus.REQ0_VALID) return 0;
    if (bus.REQ1_VALID) return 1;
    return -1;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [7:0] len);
    int beats;
    int off;
    beats = int'(len) + 1;
    off   = int'(addr & 32'h0000_0FFF);
    return (beats > MAX_LEN) || (off + beats * BEAT_BYTES > 4096);
  endfunction

  task automatic model_step();
    int s;
    bit match;
    if (!rst_n) begin
      m_open = 0; m_sent = 0; m_rep = 0; m_stray = 0;
      m_owner = 0; m_last = 1; m_resp = 2'b00;
      c_wr = 1'b0; c_addr = '0; c_len = '0;
    end else begin
      match = m_open && m_sent && !m_rep && bus.DONE_VALID && (bus.DONE_ID == 4'(m_owner));
      if (bus.DONE_VALID && !match) m_stray = 1;
      if (!m_open) begin
        s = model_sel();
        if (s >= 0) begin
          m_open  = 1;
          m_owner = s;
          c_wr    = (s == 1) ? bus.REQ1_WRITE : bus.REQ0_WRITE;
          c_addr  = (s == 1) ? bus.REQ1_ADDR  : bus.REQ0_ADDR;
          c_len   = (s == 1) ? bus.REQ1_LEN   : bus.REQ0_LEN;
          m_sent  = 0;
          m_rep   = model_err(c_addr, c_len);
          m_resp  = 2'b10;
        end
      end else if (m_rep) begin
        m_last = m_owner;
        m_open = 0;
        m_rep  = 0;
      end else if (!m_sent) begin
        if (bus.CMD_READY) m_sent = 1;
      end else if (match) begin
        m_resp = bus.DONE_RESP;
        m_rep  = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every DUT output against the model.
  initial forever begin
    int s;
    bit d0, d1;
    @(negedge clk);
    if (cmp_en) begin
      s  = m_open ? -1 : model_sel();
      d0 = m_rep && (m_owner == 0);
      d1 = m_rep && (m_owner == 1);
      check("m_req0_ready", 32'(bus.REQ0_READY), 32'(s == 0));
      check("m_req1_ready", 32'(bus.REQ1_READY), 32'(s == 1));
      check("m_cmd_valid", 32'(bus.CMD_VALID), 32'(m_open && !m_sent && !m_rep));
      check("m_cmd_write", 32'(bus.CMD_WRITE), 32'(c_wr));
      check("m_cmd_addr", bus.CMD_ADDR, c_addr);
      check("m_cmd_len", 32'(bus.CMD_LEN), 32'(c_len));
      check("m_cmd_id", 32'(bus.CMD_ID), 32'(m_owner));
      check("m_req0_done", 32'(bus.REQ0_DONE), 32'(d0));
      check("m_req1_done", 32'(bus.REQ1_DONE), 32'(d1));
      if (d0) check("m_req0_resp", 32'(bus.REQ0_RESP), 32'(m_resp));
      if (d1) check("m_req1_resp", 32'(bus.REQ1_RESP), 32'(m_resp));
      check("m_stray", 32'(bus.STRAY_DONE), 32'(m_stray));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic w,
                         input logic [31:0] a, input logic [7:0] l);
    if (n == 0) begin
      bus.REQ0_VALID = v; bus.REQ0_WRITE = w; bus.REQ0_ADDR = a; bus.REQ0_LEN = l;
    end else begin
      bus.REQ1_VALID = v; bus.REQ1_WRITE = w; bus.REQ1_ADDR = a; bus.REQ1_LEN = l;
    end
  endtask

  task automatic set_valid(input int n, input logic v);
    if (n == 0) bus.REQ0_VALID = v;
    else        bus.REQ1_VALID = v;
  endtask

  function automatic logic get_done(input int n);
    return (n == 0) ? bus.REQ0_DONE : bus.REQ1_DONE;
  endfunction

  function automatic logic [1:0] get_resp(input int n);
    return (n == 0) ? bus.REQ0_RESP : bus.REQ1_RESP;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Called just after an edge; takes the next issued command, completes it, checks the pulse.
  task automatic serve(input int owner, input logic [1:0] resp, input logic [31:0] a,
                       input logic [7:0] l, input logic [1:0] drop);
    int k;
    k = 0;
    bus.CMD_READY = 1'b1;
    @(negedge clk);
    while (!bus.CMD_VALID && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("serve_cmd_valid", 32'(bus.CMD_VALID), 32'd1);
    check("serve_cmd_id", 32'(bus.CMD_ID), 32'(owner));
    check("serve_cmd_addr", bus.CMD_ADDR, a);
    check("serve_cmd_len", 32'(bus.CMD_LEN), 32'(l));
    step();
    bus.CMD_READY = 1'b0;
    if (drop[0]) bus.REQ0_VALID = 1'b0;
    if (drop[1]) bus.REQ1_VALID = 1'b0;
    step();
    bus.DONE_VALID = 1'b1; bus.DONE_ID = 4'(owner); bus.DONE_RESP = resp;
    step();
    bus.DONE_VALID = 1'b0;
    @(negedge clk);
    check("serve_done", 32'(get_done(owner)), 32'd1);
    check("serve_resp", 32'(get_resp(owner)), 32'(resp));
    check("serve_other_done", 32'(get_done(1 - owner)), 32'd0);
    step();
  endtask

  task automatic reject(input int n, input logic [31:0] a, input logic [7:0] l);
    set_req(n, 1'b1, 1'b0, a, l);
    @(negedge clk);
    check("rej_ready", 32'(n == 0 ? bus.REQ0_READY : bus.REQ1_READY), 32'd1);
    step();
    set_valid(n, 1'b0);
    @(negedge clk);
    check("rej_done", 32'(get_done(n)), 32'd1);
    check("rej_resp", 32'(get_resp(n)), 32'd2);
    check("rej_no_cmd", 32'(bus.CMD_VALID), 32'd0);
    step();
  endtask

  task automatic new_cmd(input int n);
    logic [31:0] a;
    logic [7:0]  l;
    case ($urandom_range(0, 3))
      0:       l = 8'($urandom_range(0, 15));
      1:       l = 8'($urandom_range(14, 17));
      2:       l = 8'($urandom);
      default: l = 8'($urandom_range(0, 3));
    endcase
    case ($urandom_range(0, 2))
      0:       a = $urandom;
      1:       a = ($urandom & 32'hFFFF_F000) |
                   ((32'h1000 - 32'($urandom_range(1, 20)) * 32'd4) & 32'h0000_0FFF);
      default: a = $urandom & 32'h0000_0FFC;
    endcase
    set_req(n, 1'b1, 1'($urandom), a, l);
  endtask

  initial begin
    logic       r0, r1, hs, v, rd;
    logic [3:0] cid, pid;
    bit         pend;
    int         lat;

    set_req(0, 1'b0, 1'b0, 32'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 8'h0);
    bus.CMD_READY = 1'b0; bus.DONE_VALID = 1'b0; bus.DONE_ID = 4'h0; bus.DONE_RESP = 2'b00;
    rst_n = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_cmd_valid", 32'(bus.CMD_VALID), 32'd0);
    check("rst_cmd_addr", bus.CMD_ADDR, 32'd0);
    check("rst_cmd_id", 32'(bus.CMD_ID), 32'd0);
    check("rst_req0_done", 32'(bus.REQ0_DONE), 32'd0);
    check("rst_req1_resp", 32'(bus.REQ1_RESP), 32'd0);
    check("rst_stray", 32'(bus.STRAY_DONE), 32'd0);
    step();
    rst_n = 1'b1;

    // Single write
    set_req(0, 1'b1, 1'b1, 32'h4, 8'd3);
    bus.CMD_READY = 1'b1;
    @(negedge clk);
    check("t1_ready0", 32'(bus.REQ0_READY), 32'd1);
    check("t1_ready1", 32'(bus.REQ1_READY), 32'd0);
    step();
    bus.REQ0_VALID = 1'b0;
    @(negedge clk);
    check("t1_cmd_valid", 32'(bus.CMD_VALID), 32'd1);
    check("t1_cmd_addr", bus.CMD_ADDR, 32'h4);
    check("t1_cmd_len", 32'(bus.CMD_LEN), 32'd3);
    check("t1_cmd_id", 32'(bus.CMD_ID), 32'd0);
    check("t1_cmd_write", 32'(bus.CMD_WRITE), 32'd1);
    step();
    bus.CMD_READY = 1'b0;
    @(negedge clk);
    check("t1_cmd_drop", 32'(bus.CMD_VALID), 32'd0);
    step();
    step();
    bus.DONE_VALID = 1'b1; bus.DONE_ID = 4'd0; bus.DONE_RESP = 2'b00;
    step();
    bus.DONE_VALID = 1'b0;
    @(negedge clk);
    check("t1_done", 32'(bus.REQ0_DONE), 32'd1);
    check("t1_resp", 32'(bus.REQ0_RESP), 32'd0);
    step();
    @(negedge clk);
    check("t1_done_pulse", 32'(bus.REQ0_DONE), 32'd0);
    step();

    // Contention from reset: 0, 1, 0, 1
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h40, 8'd1);
    set_req(1, 1'b1, 1'b1, 32'h80, 8'd2);
    @(negedge clk);
    check("t2_ready0", 32'(bus.REQ0_READY), 32'd1);
    check("t2_ready1", 32'(bus.REQ1_READY), 32'd0);
    step();
    serve(0, 2'b00, 32'h40, 8'd1, 2'b00);
    serve(1, 2'b00, 32'h80, 8'd2, 2'b00);
    serve(0, 2'b00, 32'h40, 8'd1, 2'b00);
    serve(1, 2'b00, 32'h80, 8'd2, 2'b11);

    // 4 KB and length screening
    set_req(1, 1'b1, 1'b0, 32'hFF8, 8'd1);
    serve(1, 2'b00, 32'hFF8, 8'd1, 2'b10);
    reject(1, 32'hFFC, 8'd1);
    reject(0, 32'h0, 8'd16);
    set_req(0, 1'b1, 1'b1, 32'hFC0, 8'd15);
    serve(0, 2'b00, 32'hFC0, 8'd15, 2'b01);

    // Engine backpressure; REQ0 held pending throughout
    set_req(0, 1'b1, 1'b1, 32'h100, 8'd7);
    set_req(1, 1'b1, 1'b0, 32'h200, 8'd3);
    bus.CMD_READY = 1'b0;
    @(negedge clk);
    check("t4_ready1", 32'(bus.REQ1_READY), 32'd1);
    check("t4_ready0", 32'(bus.REQ0_READY), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(bus.CMD_VALID), 32'd1);
      check("t4_hold_addr", bus.CMD_ADDR, 32'h200);
      check("t4_hold_rdy", 32'({bus.REQ0_READY, bus.REQ1_READY}), 32'd0);
      step();
    end
    serve(1, 2'b00, 32'h200, 8'd3, 2'b10);
    serve(0, 2'b01, 32'h100, 8'd7, 2'b01);

    // Stray completion while busy, then the matching one
    set_req(0, 1'b1, 1'b0, 32'h300, 8'd0);
    bus.CMD_READY = 1'b1;
    step();
    bus.REQ0_VALID = 1'b0;
    step();
    bus.CMD_READY = 1'b0;
    bus.DONE_VALID = 1'b1; bus.DONE_ID = 4'd1; bus.DONE_RESP = 2'b11;
    step();
    bus.DONE_VALID = 1'b0;
    @(negedge clk);
    check("t5_stray", 32'(bus.STRAY_DONE), 32'd1);
    check("t5_no_done", 32'({bus.REQ0_DONE, bus.REQ1_DONE}), 32'd0);
    step();
    bus.DONE_VALID = 1'b1; bus.DONE_ID = 4'd0; bus.DONE_RESP = 2'b01;
    step();
    bus.DONE_VALID = 1'b0;
    @(negedge clk);
    check("t5_done", 32'(bus.REQ0_DONE), 32'd1);
    check("t5_resp", 32'(bus.REQ0_RESP), 32'd1);
    step();

    // Completion while idle, then reset during BUSY
    do_reset();
    @(negedge clk);
    check("t6_stray_clr", 32'(bus.STRAY_DONE), 32'd0);
    step();
    bus.DONE_VALID = 1'b1; bus.DONE_ID = 4'd0;
    step();
    bus.DONE_VALID = 1'b0;
    @(negedge clk);
    check("t6_stray_idle", 32'(bus.STRAY_DONE), 32'd1);
    step();
    set_req(1, 1'b1, 1'b1, 32'h500, 8'd2);
    bus.CMD_READY = 1'b1;
    step();
    bus.REQ1_VALID = 1'b0;
    step();
    bus.CMD_READY = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h600, 8'd4);
    set_req(1, 1'b1, 1'b0, 32'h700, 8'd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_cmd_valid", 32'(bus.CMD_VALID), 32'd0);
    check("t6_cmd_fields", 32'({bus.CMD_WRITE, bus.CMD_LEN, bus.CMD_ID}), 32'd0);
    check("t6_cmd_addr", bus.CMD_ADDR, 32'd0);
    check("t6_dones", 32'({bus.REQ0_DONE, bus.REQ1_DONE, bus.REQ0_RESP, bus.REQ1_RESP}), 32'd0);
    check("t6_stray", 32'(bus.STRAY_DONE), 32'd0);
    check("t6_ready0", 32'(bus.REQ0_READY), 32'd1);
    check("t6_ready1", 32'(bus.REQ1_READY), 32'd0);
    step();
    serve(0, 2'b00, 32'h600, 8'd4, 2'b11);

    // Randomized traffic; later rounds also inject unexpected completions
    for (int round = 0; round < 4; round++) begin
      set_req(0, 1'b0, 1'b0, 32'h0, 8'h0);
      set_req(1, 1'b0, 1'b0, 32'h0, 8'h0);
      bus.CMD_READY = 1'b0; bus.DONE_VALID = 1'b0;
      pend = 0; lat = 0; pid = 4'h0;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        r0  = bus.REQ0_READY;
        r1  = bus.REQ1_READY;
        hs  = bus.CMD_VALID && bus.CMD_READY;
        cid = bus.CMD_ID;
        step();
        for (int n = 0; n < 2; n++) begin
          v  = (n == 0) ? bus.REQ0_VALID : bus.REQ1_VALID;
          rd = (n == 0) ? r0 : r1;
          if (v && !rd) begin
            if ($urandom_range(0, 23) == 0) set_valid(n, 1'b0);
          end else if ($urandom_range(0, 1) == 0) begin
            new_cmd(n);
          end else begin
            set_valid(n, 1'b0);
          end
        end
        bus.DONE_VALID = 1'b0;
        if (pend) begin
          if (lat == 0) begin
            bus.DONE_VALID = 1'b1; bus.DONE_ID = pid; bus.DONE_RESP = 2'($urandom);
            pend = 0;
          end else begin
            lat--;
          end
        end
        if (hs) begin
          pend = 1; lat = $urandom_range(0, 3); pid = cid;
        end
        if (round >= 2 && !bus.DONE_VALID && $urandom_range(0, 63) == 0) begin
          bus.DONE_VALID = 1'b1; bus.DONE_ID = 4'($urandom_range(0, 3)); bus.DONE_RESP = 2'($urandom);
        end
        bus.CMD_READY = 1'($urandom);
      end
    end

    set_req(0, 1'b0, 1'b0, 32'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 8'h0);
    bus.DONE_VALID = 1'b0;
    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
